// File: rtl/dm_bus_master_pkg.sv
// Shared encodings for the memory-stage data bus master: access sizes,
// FSM states, bus width and the alignment rule.
package dm_bus_master_pkg;

  localparam int BUS_W = 32;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Size code 3 behaves as a word access.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic mis;
    case (size)
      SZ_BYTE: mis = 1'b0;
      SZ_HALF: mis = addr_lo[0];
      default: mis = (addr_lo != 2'b00);
    endcase
    return mis;
  endfunction

endpackage

// File: rtl/dm_lane_align.sv
// Byte-lane steering: enables and replicated store data for the request,
// lane selection and extension of read data for the response.
module dm_lane_align
  import dm_bus_master_pkg::*;
(
  input  logic [1:0]       i_req_size,
  input  logic [1:0]       i_req_addr_lo,
  input  logic [BUS_W-1:0] i_req_wdata,
  input  logic [1:0]       i_rsp_size,
  input  logic             i_rsp_sext,
  input  logic [1:0]       i_rsp_addr_lo,
  input  logic [BUS_W-1:0] i_rsp_rdata,
  output logic [3:0]       o_be,
  output logic [BUS_W-1:0] o_wdata,
  output logic [BUS_W-1:0] o_rdata
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_rsp_rdata[{i_rsp_addr_lo, 3'b000} +: 8];
  assign w_half = i_rsp_rdata[{i_rsp_addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    o_be    = 4'b1111;
    o_wdata = i_req_wdata;
    case (i_req_size)
      SZ_BYTE: begin
        o_be    = 4'b0001 << i_req_addr_lo;
        o_wdata = {4{i_req_wdata[7:0]}};
      end
      SZ_HALF: begin
        o_be    = 4'b0011 << {i_req_addr_lo[1], 1'b0};
        o_wdata = {2{i_req_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    o_rdata = i_rsp_rdata;
    case (i_rsp_size)
      SZ_BYTE: o_rdata = {{24{i_rsp_sext & w_byte[7]}}, w_byte};
      SZ_HALF: o_rdata = {{16{i_rsp_sext & w_half[15]}}, w_half};
      default: ;
    endcase
  end

endmodule

// File: rtl/dm_bus_master.sv
// Memory-stage load/store master: runs one req/ack bus transaction per M-stage
// access, stalls the pipeline meanwhile and returns aligned load data.
module dm_bus_master
  import dm_bus_master_pkg::*;
#(
  parameter int TIMEOUT   = 255,
  parameter int TIMEOUT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_mem_valid,
  input  logic             i_mem_we,
  input  logic [1:0]       i_mem_size,
  input  logic             i_mem_sext,
  input  logic [BUS_W-1:0] i_mem_addr,
  input  logic [BUS_W-1:0] i_mem_wdata,
  input  logic             i_flush,
  output logic             o_stall,
  output logic [BUS_W-1:0] o_rdata,
  output logic             o_rdata_valid,
  output logic             o_adel,
  output logic             o_ades,
  output logic             o_bus_err,
  output logic             o_bus_req,
  output logic             o_bus_we,
  output logic [BUS_W-1:0] o_bus_addr,
  output logic [3:0]       o_bus_be,
  output logic [BUS_W-1:0] o_bus_wdata,
  input  logic             i_bus_ack,
  input  logic             i_bus_err_in,
  input  logic [BUS_W-1:0] i_bus_rdata
);

  localparam logic [TIMEOUT_W:0] TIMEOUT_L = (TIMEOUT_W+1)'(TIMEOUT);

  state_t               r_state;
  logic [TIMEOUT_W-1:0] r_cnt;
  logic [1:0]           r_size;
  logic                 r_sext;
  logic [1:0]           r_addr_lo;
  logic [BUS_W-1:0]     r_rdata;
  logic                 r_rdata_valid;
  logic                 r_bus_err;
  logic                 r_bus_req;
  logic                 r_bus_we;
  logic [BUS_W-1:0]     r_bus_addr;
  logic [3:0]           r_bus_be;
  logic [BUS_W-1:0]     r_bus_wdata;

  logic                 w_mis;
  logic                 w_start;
  logic [TIMEOUT_W:0]   w_cnt_inc;
  logic [3:0]           w_be;
  logic [BUS_W-1:0]     w_wdata;
  logic [BUS_W-1:0]     w_rdata_ext;

  assign w_mis     = is_misaligned(i_mem_size, i_mem_addr[1:0]);
  // Gated by rst_n so the pipeline is never stalled while held in reset.
  assign w_start   = rst_n & (r_state == ST_IDLE) & i_mem_valid & ~w_mis & ~i_flush;
  assign w_cnt_inc = {1'b0, r_cnt} + 1'b1;

  assign o_adel = i_mem_valid & ~i_mem_we & w_mis;
  assign o_ades = i_mem_valid &  i_mem_we & w_mis;
  assign o_stall = w_start | (r_state == ST_BUSY);

  dm_lane_align u_lane_align (
    .i_req_size    (i_mem_size),
    .i_req_addr_lo (i_mem_addr[1:0]),
    .i_req_wdata   (i_mem_wdata),
    .i_rsp_size    (r_size),
    .i_rsp_sext    (r_sext),
    .i_rsp_addr_lo (r_addr_lo),
    .i_rsp_rdata   (i_bus_rdata),
    .o_be          (w_be),
    .o_wdata       (w_wdata),
    .o_rdata       (w_rdata_ext)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_size        <= SZ_BYTE;
      r_sext        <= 1'b0;
      r_addr_lo     <= 2'b00;
      r_rdata       <= '0;
      r_rdata_valid <= 1'b0;
      r_bus_err     <= 1'b0;
      r_bus_req     <= 1'b0;
      r_bus_we      <= 1'b0;
      r_bus_addr    <= '0;
      r_bus_be      <= 4'b0000;
      r_bus_wdata   <= '0;
    end else begin
      r_rdata_valid <= 1'b0;
      r_bus_err     <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            r_bus_req   <= 1'b1;
            r_bus_we    <= i_mem_we;
            r_bus_addr  <= {i_mem_addr[BUS_W-1:2], 2'b00};
            r_bus_be    <= w_be;
            r_bus_wdata <= w_wdata;
            r_size      <= i_mem_size;
            r_sext      <= i_mem_sext;
            r_addr_lo   <= i_mem_addr[1:0];
            r_cnt       <= '0;
            r_state     <= ST_BUSY;
          end
        end
        ST_BUSY: begin
          if (!w_cnt_inc[TIMEOUT_W]) r_cnt <= w_cnt_inc[TIMEOUT_W-1:0];
          // An ack arriving on the final allowed cycle still wins over the timeout.
          if (i_bus_ack) begin
            r_bus_req     <= 1'b0;
            r_bus_err     <= i_bus_err_in;
            r_rdata_valid <= ~r_bus_we;
            if (!r_bus_we) r_rdata <= w_rdata_ext;
            r_state       <= ST_DONE;
          end else if (w_cnt_inc == TIMEOUT_L) begin
            r_bus_req     <= 1'b0;
            r_bus_err     <= 1'b1;
            r_rdata_valid <= ~r_bus_we;
            if (!r_bus_we) r_rdata <= '0;
            r_state       <= ST_DONE;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign o_rdata       = r_rdata;
  assign o_rdata_valid = r_rdata_valid;
  assign o_bus_err     = r_bus_err;
  assign o_bus_req     = r_bus_req;
  assign o_bus_we      = r_bus_we;
  assign o_bus_addr    = r_bus_addr;
  assign o_bus_be      = r_bus_be;
  assign o_bus_wdata   = r_bus_wdata;

endmodule

// File: tb/tb_dm_bus_master.sv
// Bench for dm_bus_master: directed cases plus randomized load/store traffic
// checked against a size/offset arithmetic model of the bus contract.
module tb_dm_bus_master;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_mem_valid = 1'b0;
  logic        i_mem_we = 1'b0;
  logic [1:0]  i_mem_size = 2'd0;
  logic        i_mem_sext = 1'b0;
  logic [31:0] i_mem_addr = 32'd0;
  logic [31:0] i_mem_wdata = 32'd0;
  logic        i_flush = 1'b0;
  logic        i_bus_ack = 1'b0;
  logic        i_bus_err_in = 1'b0;
  logic [31:0] i_bus_rdata = 32'd0;
  logic        o_stall, o_rdata_valid, o_adel, o_ades, o_bus_err, o_bus_req, o_bus_we;
  logic [31:0] o_rdata, o_bus_addr, o_bus_wdata;
  logic [3:0]  o_bus_be;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_rdata = 32'd0;

  always #5 clk = ~clk;

  dm_bus_master #(.TIMEOUT(TO), .TIMEOUT_W(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_mem_valid(i_mem_valid), .i_mem_we(i_mem_we), .i_mem_size(i_mem_size),
    .i_mem_sext(i_mem_sext), .i_mem_addr(i_mem_addr), .i_mem_wdata(i_mem_wdata),
    .i_flush(i_flush), .o_stall(o_stall), .o_rdata(o_rdata), .o_rdata_valid(o_rdata_valid),
    .o_adel(o_adel), .o_ades(o_ades), .o_bus_err(o_bus_err), .o_bus_req(o_bus_req),
    .o_bus_we(o_bus_we), .o_bus_addr(o_bus_addr), .o_bus_be(o_bus_be),
    .o_bus_wdata(o_bus_wdata), .i_bus_ack(i_bus_ack), .i_bus_err_in(i_bus_err_in),
    .i_bus_rdata(i_bus_rdata)
  );

  // One M-stage access; lat = cycles of bus_req before ack (>= TO means never).
  task automatic run_txn(input logic we, input logic [1:0] size, input logic sext,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] rd, input int lat, input logic err,
                         input logic flush_busy, input string name);
    int          nb, off, req_cnt, stall_cnt, exp_req;
    logic        mis, ack_ok, done;
    logic [3:0]  e_be;
    logic [31:0] e_wd, e_rd, mask;
    nb   = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
    mis  = (addr % nb) != 0;
    off  = int'(addr % 4);
    e_be = 4'(((1 << nb) - 1) << off);
    e_wd = (nb == 1) ? (wdata & 32'hFF) * 32'h0101_0101 :
           (nb == 2) ? (wdata & 32'hFFFF) * 32'h0001_0001 : wdata;
    mask = (nb == 4) ? 32'hFFFF_FFFF : (32'd1 << (8 * nb)) - 32'd1;
    e_rd = (rd >> (8 * off)) & mask;
    if (sext && nb < 4 && e_rd[8*nb-1]) e_rd = e_rd | ~mask;
    ack_ok  = (lat < TO);
    exp_req = ack_ok ? lat + 1 : TO;

    @(negedge clk);
    i_mem_valid = 1'b1; i_mem_we = we; i_mem_size = size; i_mem_sext = sext;
    i_mem_addr = addr; i_mem_wdata = wdata; i_flush = 1'b0; i_bus_ack = 1'b0;
    #1;
    n_cmp++;
    if (o_rdata_valid !== 1'b0 || o_bus_err !== 1'b0 || o_rdata !== exp_rdata) begin
      n_err++;
      $display("FAIL %s idle_outputs: rv=%0d err=%0d rdata=%h, want rv=0 err=0 rdata=%h",
               name, o_rdata_valid, o_bus_err, o_rdata, exp_rdata);
    end
    n_cmp++;
    if (o_adel !== (!we && mis) || o_ades !== (we && mis)) begin
      n_err++;
      $display("FAIL %s addr_exc: adel=%0d ades=%0d, want adel=%0d ades=%0d",
               name, o_adel, o_ades, !we && mis, we && mis);
    end
    n_cmp++;
    if (o_stall !== !mis) begin
      n_err++;
      $display("FAIL %s start_stall: stall=%0d, want %0d", name, o_stall, !mis);
    end
    if (mis) begin
      @(negedge clk); #1;
      n_cmp++;
      if (o_bus_req !== 1'b0 || o_stall !== 1'b0) begin
        n_err++;
        $display("FAIL %s misaligned_quiet: req=%0d stall=%0d, want 0 0", name, o_bus_req, o_stall);
      end
      $display("txn %s we=%0d size=%0d addr=%h misaligned adel=%0d ades=%0d", name, we, size, addr, o_adel, o_ades);
      i_mem_valid = 1'b0;
      return;
    end

    req_cnt = 0; stall_cnt = 1; done = 1'b0;
    for (int c = 1; c <= TO + 4 && !done; c++) begin
      @(negedge clk);
      if (o_bus_req) begin
        req_cnt++;
        n_cmp++;
        if ({o_bus_we, o_bus_addr, o_bus_be, o_bus_wdata} !== {we, addr & ~32'h3, e_be, e_wd}) begin
          n_err++;
          $display("FAIL %s bus_fields cyc%0d: we=%0d addr=%h be=%b wd=%h, want we=%0d addr=%h be=%b wd=%h",
                   name, req_cnt, o_bus_we, o_bus_addr, o_bus_be, o_bus_wdata, we, addr & ~32'h3, e_be, e_wd);
        end
        i_bus_ack    = (lat < TO) && (req_cnt == lat + 1);
        i_bus_err_in = i_bus_ack & err;
        i_bus_rdata  = i_bus_ack ? rd : $urandom;
        i_flush      = flush_busy & 1'($urandom_range(0, 1));
      end else begin
        i_bus_ack = 1'b0; i_bus_err_in = 1'b0; i_flush = 1'b0;
        done = 1'b1;
      end
      #1;
      if (o_stall) stall_cnt++;
    end
    n_cmp++;
    if (!done) begin
      n_err++;
      $display("FAIL %s completion: no DONE within %0d cycles, want completion", name, TO + 4);
    end
    n_cmp++;
    if (req_cnt != exp_req || stall_cnt != exp_req + 1) begin
      n_err++;
      $display("FAIL %s timing: req_cycles=%0d stall_cycles=%0d, want %0d %0d",
               name, req_cnt, stall_cnt, exp_req, exp_req + 1);
    end
    if (!we) exp_rdata = ack_ok ? e_rd : 32'd0;
    n_cmp++;
    if (o_rdata_valid !== !we || o_bus_err !== (ack_ok ? err : 1'b1) || o_rdata !== exp_rdata) begin
      n_err++;
      $display("FAIL %s done_outputs: rv=%0d err=%0d rdata=%h, want rv=%0d err=%0d rdata=%h",
               name, o_rdata_valid, o_bus_err, o_rdata, !we, ack_ok ? err : 1'b1, exp_rdata);
    end
    $display("txn %s we=%0d size=%0d sext=%0d addr=%h be=%b lat=%0d rdata=%h err=%0d",
             name, we, size, sext, addr, e_be, lat, o_rdata, o_bus_err);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    i_mem_valid = 1'b1; i_mem_addr = 32'h100;
    @(negedge clk); #1;
    n_cmp++;
    if ({o_bus_req, o_bus_we, o_bus_addr, o_bus_be, o_bus_wdata, o_rdata, o_rdata_valid, o_bus_err, o_stall} !== '0) begin
      n_err++;
      $display("FAIL reset_state: req=%0d we=%0d addr=%h be=%b wd=%h rdata=%h rv=%0d err=%0d stall=%0d, want all 0",
               o_bus_req, o_bus_we, o_bus_addr, o_bus_be, o_bus_wdata, o_rdata, o_rdata_valid, o_bus_err, o_stall);
    end
    i_mem_valid = 1'b0;
    rst_n = 1'b1;
    exp_rdata = 32'd0;
    $display("txn reset outputs checked");
  endtask

  task automatic test_directed();
    run_txn(1'b0, 2'd2, 1'b0, 32'h0000_1004, 32'h0, 32'hDEAD_BEEF, 3, 1'b0, 1'b0, "lw_1004");
    run_txn(1'b0, 2'd0, 1'b1, 32'h0000_2003, 32'h0, 32'h80FF_FF7F, 1, 1'b0, 1'b0, "lb_2003");
    run_txn(1'b0, 2'd0, 1'b0, 32'h0000_2003, 32'h0, 32'h80FF_FF7F, 0, 1'b0, 1'b0, "lbu_2003");
    run_txn(1'b1, 2'd1, 1'b0, 32'h0000_3002, 32'h1234_ABCD, 32'h0, 2, 1'b0, 1'b0, "sh_3002");
    run_txn(1'b0, 2'd1, 1'b1, 32'h0000_3002, 32'h0, 32'h8001_7FFF, 0, 1'b0, 1'b0, "lh_3002");
    i_mem_valid = 1'b0;
  endtask

  task automatic test_misaligned();
    run_txn(1'b0, 2'd2, 1'b0, 32'h0000_4002, 32'h0, 32'h0, 0, 1'b0, 1'b0, "lw_4002");
    run_txn(1'b1, 2'd1, 1'b0, 32'h0000_4001, 32'h5555, 32'h0, 0, 1'b0, 1'b0, "sh_4001");
    run_txn(1'b1, 2'd3, 1'b0, 32'h0000_4003, 32'h5555, 32'h0, 0, 1'b0, 1'b0, "sz3_4003");
  endtask

  task automatic test_timeout();
    run_txn(1'b0, 2'd2, 1'b0, 32'h0000_5000, 32'h0, 32'h0, TO + 5, 1'b0, 1'b0, "lw_timeout");
    run_txn(1'b0, 2'd2, 1'b0, 32'h0000_5004, 32'h0, 32'hCAFE_F00D, TO - 1, 1'b0, 1'b0, "lw_ack_at_limit");
    run_txn(1'b1, 2'd2, 1'b0, 32'h0000_5008, 32'h0BAD_0BAD, 32'h0, TO + 5, 1'b0, 1'b0, "sw_timeout");
    run_txn(1'b0, 2'd2, 1'b0, 32'h0000_500C, 32'h0, 32'h1111_2222, 2, 1'b1, 1'b1, "lw_bus_err_flush");
    i_mem_valid = 1'b0;
  endtask

  task automatic test_flush_idle();
    @(negedge clk);
    i_mem_valid = 1'b1; i_mem_we = 1'b0; i_mem_size = 2'd2; i_mem_addr = 32'h6000; i_flush = 1'b1;
    #1;
    n_cmp++;
    if (o_stall !== 1'b0) begin
      n_err++;
      $display("FAIL flush_idle_stall: stall=%0d, want 0", o_stall);
    end
    repeat (3) @(negedge clk);
    #1;
    n_cmp++;
    if (o_bus_req !== 1'b0 || o_stall !== 1'b0) begin
      n_err++;
      $display("FAIL flush_idle_req: req=%0d stall=%0d, want 0 0", o_bus_req, o_stall);
    end
    i_flush = 1'b0; i_mem_valid = 1'b0;
    $display("txn flush_idle load at %h blocked", i_mem_addr);
  endtask

  task automatic test_reset_mid_busy();
    @(negedge clk);
    i_mem_valid = 1'b1; i_mem_we = 1'b0; i_mem_size = 2'd2; i_mem_addr = 32'h7000;
    i_bus_ack = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if (o_bus_req !== 1'b1) begin
      n_err++;
      $display("FAIL mid_busy_req: req=%0d, want 1", o_bus_req);
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (o_bus_req !== 1'b0 || o_stall !== 1'b0 || o_bus_be !== 4'b0000) begin
      n_err++;
      $display("FAIL async_reset: req=%0d stall=%0d be=%b, want 0 0 0000", o_bus_req, o_stall, o_bus_be);
    end
    @(negedge clk);
    i_mem_valid = 1'b0;
    rst_n = 1'b1;
    exp_rdata = 32'd0;
    $display("txn reset_mid_busy request dropped");
  endtask

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      logic        we, sext, err;
      logic [1:0]  size;
      logic [31:0] addr;
      int          lat;
      we   = 1'($urandom_range(0, 1));
      size = 2'($urandom_range(0, 3));
      sext = 1'($urandom_range(0, 1));
      addr = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (size == 2'd1) addr[0] = 1'b0;
        else if (size != 2'd0) addr[1:0] = 2'b00;
      end
      lat = $urandom_range(0, TO + 1);
      err = ($urandom_range(0, 7) == 0);
      run_txn(we, size, sext, addr, $urandom, $urandom, lat, err, 1'($urandom_range(0, 1)),
              $sformatf("rand%0d", i));
    end
    i_mem_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_misaligned();
    test_timeout();
    test_flush_idle();
    test_reset_mid_busy();
    test_random();
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
